// File: rtl/packet_mmu.sv
// packet_mmu: packet memory manager with a logical-to-physical map table,
// a block allocation bitmap and an internal packet SRAM.
//
// Each logical address owns at most one physical block of BURST words. A
// write goes into a freshly allocated block and only replaces the map entry
// once the whole packet has been captured. When no block is free, a write to
// an already-mapped address overwrites that block in place.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start, op   command request (00 write, 01 read, 10 release, 11 reserved)
//   addr        logical packet address, sampled at acceptance
//   wr_data     write word; word 0 is presented at acceptance
//   ready       idle, a command can be accepted
//   rd_valid    rd_data carries a packet word (registered)
//   rd_data     read word (registered)
//   done        one-cycle pulse on successful completion
//   err         one-cycle pulse on a rejected command
//   free_cnt    number of free physical blocks
module packet_mmu #(
    parameter int unsigned DATA_BIT = 8,
    parameter int unsigned ADDR_BIT = 4,
    parameter int unsigned BLK_BIT  = 3,
    parameter int unsigned BURST    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [ADDR_BIT-1:0] addr,
    input  logic [DATA_BIT-1:0] wr_data,
    output logic                ready,
    output logic                rd_valid,
    output logic [DATA_BIT-1:0] rd_data,
    output logic                done,
    output logic                err,
    output logic [BLK_BIT:0]    free_cnt
);

    localparam int NMAP    = 2 ** ADDR_BIT;
    localparam int NBLK    = 2 ** BLK_BIT;
    localparam int CNT_BIT = $clog2(BURST);
    localparam int MEM_BIT = BLK_BIT + CNT_BIT;
    localparam int DEPTH   = NBLK * BURST;

    localparam logic [1:0] OpWrite   = 2'b00;
    localparam logic [1:0] OpRead    = 2'b01;
    localparam logic [1:0] OpRelease = 2'b10;

    localparam logic [CNT_BIT-1:0] CntLast = CNT_BIT'(BURST - 1);
    localparam logic [CNT_BIT-1:0] CntOne  = CNT_BIT'(1);
    localparam logic [BLK_BIT:0]   FreeOne = (BLK_BIT + 1)'(1);
    localparam logic [BLK_BIT:0]   FreeAll = (BLK_BIT + 1)'(NBLK);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead
    } state_e;

    state_e                state_q;
    logic [CNT_BIT-1:0]    cnt_q;
    logic [ADDR_BIT-1:0]   cmd_addr_q;
    logic [BLK_BIT-1:0]    cmd_blk_q;
    logic                  in_place_q;
    logic                  map_valid_q [NMAP];
    logic [BLK_BIT-1:0]    map_blk_q   [NMAP];
    logic [NBLK-1:0]       alloc_q;       // 1 = block in use
    logic [BLK_BIT:0]      free_cnt_q;
    logic                  rd_valid_q;
    logic [DATA_BIT-1:0]   rd_data_q;
    logic                  done_q;
    logic                  err_q;

    logic [DATA_BIT-1:0]   mem [DEPTH];

    logic [BLK_BIT-1:0]    free_blk;
    logic                  have_free;
    logic                  cur_valid;
    logic [BLK_BIT-1:0]    cur_blk;
    logic                  mem_we;
    logic [MEM_BIT-1:0]    mem_waddr;

    assign have_free = (free_cnt_q != '0);
    assign cur_valid = map_valid_q[addr];
    assign cur_blk   = map_blk_q[addr];

    // Lowest-index free block; scanning downwards leaves the lowest one last.
    always_comb begin
        free_blk = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                free_blk = BLK_BIT'(i);
            end
        end
    end

    // Word 0 is written straight from the acceptance edge, the rest from WRITE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        if (state_q == StIdle) begin
            if (start && (op == OpWrite)) begin
                if (have_free) begin
                    mem_we    = 1'b1;
                    mem_waddr = {free_blk, {CNT_BIT{1'b0}}};
                end else if (cur_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {cur_blk, {CNT_BIT{1'b0}}};
                end
            end
        end else if (state_q == StWrite) begin
            mem_we    = 1'b1;
            mem_waddr = {cmd_blk_q, cnt_q};
        end
    end

    // Packet SRAM, not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cmd_addr_q <= '0;
            cmd_blk_q  <= '0;
            in_place_q <= 1'b0;
            alloc_q    <= '0;
            free_cnt_q <= FreeAll;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NMAP; i++) begin
                map_valid_q[i] <= 1'b0;
                map_blk_q[i]   <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            OpWrite: begin
                                if (have_free) begin
                                    cmd_addr_q <= addr;
                                    cmd_blk_q  <= free_blk;
                                    in_place_q <= 1'b0;
                                    cnt_q      <= CntOne;
                                    state_q    <= StWrite;
                                end else if (cur_valid) begin
                                    cmd_addr_q <= addr;
                                    cmd_blk_q  <= cur_blk;
                                    in_place_q <= 1'b1;
                                    cnt_q      <= CntOne;
                                    state_q    <= StWrite;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OpRead: begin
                                if (cur_valid) begin
                                    cmd_blk_q <= cur_blk;
                                    cnt_q     <= '0;
                                    state_q   <= StRead;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OpRelease: begin
                                if (cur_valid) begin
                                    map_valid_q[addr] <= 1'b0;
                                    alloc_q[cur_blk]  <= 1'b0;
                                    free_cnt_q        <= free_cnt_q + FreeOne;
                                    done_q            <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                StWrite: begin
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        // Commit: the old block (if any) stays readable until now.
                        // The new block was free, so it never equals the old one.
                        if (!in_place_q) begin
                            map_valid_q[cmd_addr_q] <= 1'b1;
                            map_blk_q[cmd_addr_q]   <= cmd_blk_q;
                            alloc_q[cmd_blk_q]      <= 1'b1;
                            if (map_valid_q[cmd_addr_q]) begin
                                alloc_q[map_blk_q[cmd_addr_q]] <= 1'b0;
                            end else begin
                                free_cnt_q <= free_cnt_q - FreeOne;
                            end
                        end
                    end
                end
                StRead: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= mem[{cmd_blk_q, cnt_q}];
                    cnt_q      <= cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready    = (state_q == StIdle);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign free_cnt = free_cnt_q;

endmodule

// File: doc/packet_mmu.md
# packet_mmu

Parametrised packet memory manager: stores fixed-length packets at logical addresses, maps each logical address to a physical block through an internal map table, and allocates or reclaims blocks from a free bitmap. It generalises the first-generation MMU with configurable data width, logical address space, block count and burst length. It adds an explicit release command, in-place overwrite when memory is full, and error reporting. It sits between the packet FIFO front end and the on-chip SRAM array, which is internal to this block.

## Interface
- DATA_BIT, 8: data word width.
- ADDR_BIT, 4: logical address width; 2^ADDR_BIT map entries.
- BLK_BIT, 3: physical block index width; NBLK = 2^BLK_BIT blocks.
- BURST, 8: words per packet, power of 2, ≥2; storage depth NBLK*BURST words.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command request, sampled while ready=1.
- op  in  2  00 write, 01 read, 10 release, 11 reserved.
- addr  in  ADDR_BIT  logical packet address, sampled at acceptance.
- wr_data  in  DATA_BIT  write word; word 0 is presented at acceptance.
- ready  out  1  block idle, can accept a command.
- rd_valid  out  1  rd_data carries a packet word.
- rd_data  out  DATA_BIT  read word, registered.
- done  out  1  one-cycle pulse on successful command completion.
- err  out  1  one-cycle pulse on rejected command.
- free_cnt  out  BLK_BIT+1  number of free physical blocks.

## Operation
- Map entry: a valid bit plus a BLK_BIT block index. The free bitmap has one bit per block. Allocation always takes the lowest-index free block.
- FSM states: IDLE, WRITE, READ. ready=1 only in IDLE. start while ready=0 is ignored.
- Acceptance: a rising edge with state=IDLE and start=1.
- Write, free_cnt>0:
  - Allocate block B. Capture word 0 at acceptance.
  - Go to WRITE and capture words 1..BURST-1 on the next BURST-1 edges.
  - At the last capture edge: map[addr] becomes B and valid.
  - If addr was previously mapped, its old block is freed at the same edge, so net free_cnt is unchanged. Otherwise free_cnt decrements.
  - Return to IDLE. The old packet stays readable until this commit.
- Write, free_cnt=0, addr mapped: write in place into the mapped block. free_cnt unchanged.
- Write, free_cnt=0, addr unmapped: reject. err pulses, state stays IDLE, following wr_data is ignored.
- Read, addr mapped: go to READ. BURST words are output in address order from the mapped block.
- Read, addr unmapped: reject with err. No rd_valid.
- Release, addr mapped: clear the valid bit, free the block, free_cnt+1, done pulses. State stays IDLE.
- Release, addr unmapped: reject with err.
- op=11: reject with err.
- free_cnt always equals the number of zero bits in the allocation bitmap. It never exceeds NBLK and never underflows.

## Timing
- Reset values: ready=1, rd_valid=0, rd_data=0, done=0, err=0, free_cnt=NBLK; all map entries invalid; all blocks free; state IDLE. SRAM contents are not reset.
- Reset asserted mid-command abandons the command. No partial map update survives. Reset is asynchronous and takes effect immediately.
- Edge numbering: acceptance edge is E0.
- Write: words are captured at E0..E(BURST-1). done=1 in the cycle after E(BURST-1), and ready=1 in that same cycle, so back-to-back commands are allowed.
- Read: the SRAM read is registered. rd_valid=1 and rd_data=word k in the cycle after E(k+1), for k=0..BURST-1, so first-word latency is 2 edges.
  - done accompanies the last word.
  - ready returns in the cycle after E(BURST), concurrent with the last word.
- Release: done and the free_cnt update appear in the cycle after E0.
- Rejections: err appears in the cycle after E0, with ready still 1.
- The internal word counter is log2(BURST) bits and wraps to 0 at end of burst.

## Test plan
- Reset state: after reset release, ready=1, free_cnt=8, rd_valid=0, done=0, err=0.
- Write then read:
  - Write addr 1 with 08,33,ac,34,99,41,0c,14. done pulses 1 cycle after the 8th word, free_cnt=7.
  - Read addr 1. rd_valid is high for 8 cycles starting 2 edges after acceptance, carrying data in that order, with done on the last word.
- Overwrite reclaim:
  - Write addr 3, then addr 5: free_cnt=5.
  - Rewrite addr 3 with 90,d1,32,55,a7,b2,65,96: free_cnt stays 5.
  - Read addr 3 returns the new data.
- Full memory:
  - Write 8 distinct addrs (0..7): free_cnt=0.
  - Write addr 9: err pulse, ready stays 1, free_cnt=0.
  - Write addr 2 with new data: done pulses. Read addr 2 returns the new data.
- Release:
  - Release addr 5: done pulses, free_cnt increases by 1.
  - Read addr 5: err, no rd_valid.
  - Release addr 5 again: err.
  - Any command with op=11: err.
- Reset mid-write: assert rst_n=0 after the 4th word of a write to addr 1. Outputs return to their reset values, free_cnt=8, and a read of addr 1 gives err.
